// File: rtl/cpu_axi_master_bridge_if.sv
// AXI4 single-beat master bus bundle used between the CPU bridge and the interconnect.
interface cpu_axi_master_bridge_if #(
  parameter int unsigned ID_W = 4
);

  // Read address channel
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  // Read data channel
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  // Write address channel
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  // Write data channel
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  // Write response channel
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cpu_axi_master_bridge.sv
// Bridge from the CPU's stall-based memory port to single-beat AXI4 master transactions.
// One request is in flight at a time; the CPU is stalled until the DONE cycle.
module cpu_axi_master_bridge #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MASTER_ID = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read,
  input  logic [3:0]  cpu_write_en,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  cpu_axi_master_bridge_if.master axi
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        err_q, err_d;
  logic        cpu_req;
  logic        aw_done;
  logic        w_done;

  assign cpu_req = cpu_read | (|cpu_write_en);

  // State and bus-output registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      strb_q    <= 4'd0;
      rdata_q   <= 32'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: issue the request, walk the AXI handshakes, then one DONE cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    err_d     = 1'b0;
    // A channel counts as done once its VALID has dropped or is accepted this cycle.
    aw_done   = !awvalid_q || axi.awready;
    w_done    = !wvalid_q || axi.wready;

    unique case (state_q)
      StIdle: begin
        // Read wins when both are requested; the write strobes are ignored.
        if (cpu_read) begin
          addr_d    = cpu_addr;
          arvalid_d = 1'b1;
          state_d   = StRdAddr;
        end else if (|cpu_write_en) begin
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          strb_d    = cpu_write_en;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StWrReq;
        end
      end
      StRdAddr: begin
        if (arvalid_q && axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        // RLAST is not checked: the single accepted beat always ends the read.
        if (axi.rvalid && rready_q) begin
          rdata_d  = axi.rdata;
          rready_d = 1'b0;
          err_d    = (axi.rresp != 2'b00);
          state_d  = StDone;
        end
      end
      StWrReq: begin
        if (awvalid_q && axi.awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && axi.wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (axi.bvalid && bready_q) begin
          bready_d = 1'b0;
          err_d    = (axi.bresp != 2'b00);
          state_d  = StDone;
        end
      end
      StDone: begin
        // The CPU advances this cycle; its stale request must not be reissued.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Stall is combinational so the CPU freezes in the same cycle it presents a request.
  // Gated by reset so the pipeline is released while the bridge is held in reset.
  always_comb begin
    cpu_stall = 1'b0;
    if (rst) begin
      unique case (state_q)
        StIdle:                                  cpu_stall = cpu_req;
        StRdAddr, StRdData, StWrReq, StWrResp:   cpu_stall = 1'b1;
        default:                                 cpu_stall = 1'b0;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

  assign axi.arid    = ID_W'(MASTER_ID);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = ID_W'(MASTER_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = strb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;

  assign axi.bready  = bready_q;

  // IDs and RLAST carry no information with a single outstanding transfer.
  logic unused_inputs;
  assign unused_inputs = ^{axi.rid, axi.rlast, axi.bid};

endmodule
